// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
//   - Opcode values decoded from IR[31:26].
//   - Controller state encoding (4-bit, visible on state_dbg).
//   - Mux select encodings for ALUSrcB, ALUOp and PCSrc, shared with the
//     ALU decoder and the datapath.
//   - Opcode class enum produced by mips_op_class.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_ALUWB_R = 4'd7,
    S_EXEC_I  = 4'd8,
    S_ALUWB_I = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_S2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LOGIC = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    CLS_MEM       = 3'd0,
    CLS_RTYPE     = 3'd1,
    CLS_IMM_ARITH = 3'd2,
    CLS_IMM_LOGIC = 3'd3,
    CLS_BRANCH    = 3'd4,
    CLS_JUMP      = 3'd5,
    CLS_ILLEGAL   = 3'd6
  } op_class_t;

endpackage

// File: rtl/mips_op_class.sv
// Combinational opcode classifier.
//   opcode   in  6  IR[31:26]
//   op_class out    instruction class; anything unsupported is CLS_ILLEGAL
module mips_op_class
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OP_LW, OP_SW:    op_class = CLS_MEM;
      OP_R:            op_class = CLS_RTYPE;
      OP_ADDI:         op_class = CLS_IMM_ARITH;
      OP_ANDI, OP_ORI: op_class = CLS_IMM_LOGIC;
      OP_BEQ, OP_BNE:  op_class = CLS_BRANCH;
      OP_J:            op_class = CLS_JUMP;
      default:         op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multi-cycle MIPS datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback,
// stalls on mem_ready in FETCH, MEMRD and MEMWR, and raises a sticky
// mem_timeout when a single wait stretches to MEM_TIMEOUT cycles.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   opcode           IR[31:26], held stable by the datapath after IR load
//   mem_ready        memory completes the current access this cycle
//   mem_req/mem_we/IorD                     unified memory port control
//   IRWrite/PCWrite/PCWriteCond/BranchNE/PCSrc   IR and PC update
//   RegDst/MemtoReg/RegWrite                register file write port
//   ALUSrcA/ALUSrcB/ALUOp/ExtZero           ALU operand/op and imm extension
//   illegal_op       one-cycle pulse in DECODE on an unsupported opcode
//   mem_timeout      sticky memory wait timeout
//   state_dbg        current state encoding
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNE,
  output logic [1:0] PCSrc,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       ExtZero,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state_dbg
);

  state_t     state;
  op_class_t  op_class;
  logic [7:0] wait_cnt;
  logic [8:0] wait_inc;
  logic       timeout_flag;
  logic       waiting;

  mips_op_class u_op_class (
    .opcode   (opcode),
    .op_class (op_class)
  );

  assign waiting  = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign wait_inc = {1'b0, wait_cnt} + 9'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (op_class)
            CLS_MEM:                      state <= S_MEMADR;
            CLS_RTYPE:                    state <= S_EXEC_R;
            CLS_IMM_ARITH, CLS_IMM_LOGIC: state <= S_EXEC_I;
            CLS_BRANCH:                   state <= S_BRANCH;
            CLS_JUMP:                     state <= S_JUMP;
            default:                      state <= S_FETCH;
          endcase
        end
        S_MEMADR:  state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   if (mem_ready) state <= S_MEMWB;
        S_MEMWB:   state <= S_FETCH;
        S_MEMWR:   if (mem_ready) state <= S_FETCH;
        S_EXEC_R:  state <= S_ALUWB_R;
        S_ALUWB_R: state <= S_FETCH;
        S_EXEC_I:  state <= S_ALUWB_I;
        S_ALUWB_I: state <= S_FETCH;
        S_BRANCH:  state <= S_FETCH;
        S_JUMP:    state <= S_FETCH;
        default:   state <= S_FETCH;
      endcase
    end
  end

  // A waiting state can only be left on mem_ready, and every non-waiting
  // cycle clears the count, so clearing on "not stalled" also covers
  // clearing on any state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt     <= 8'd0;
      timeout_flag <= 1'b0;
    end else if (waiting && !mem_ready) begin
      if (wait_cnt != 8'hff) wait_cnt <= wait_inc[7:0];
      if ((MEM_TIMEOUT != 8'd0) && (wait_inc >= {1'b0, MEM_TIMEOUT})) timeout_flag <= 1'b1;
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  // Outputs decode the state register; FETCH's IR/PC loads are qualified
  // by mem_ready so they fire only when the fetched word is on the bus.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNE    = 1'b0;
    PCSrc       = PCSRC_ALU;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RT;
    ALUOp       = ALUOP_ADD;
    ExtZero     = 1'b0;
    illegal_op  = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB    = SRCB_IMM_S2;
          illegal_op = (op_class == CLS_ILLEGAL);
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          IorD    = 1'b1;
        end
        S_EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
        end
        S_ALUWB_R: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          if (op_class == CLS_IMM_LOGIC) begin
            ALUOp   = ALUOP_LOGIC;
            ExtZero = 1'b1;
          end
        end
        S_ALUWB_I: begin
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSrc       = PCSRC_ALUOUT;
          BranchNE    = (opcode == OP_BNE);
        end
        S_JUMP: begin
          PCWrite = 1'b1;
          PCSrc   = PCSRC_JUMP;
        end
        default: ;
      endcase
    end
    mem_timeout = timeout_flag && !rst;
    state_dbg   = state;
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl. The driver walks each
// instruction through its phases from the instruction-level rules, pushes
// one expected record per cycle, and a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam logic [7:0] TMO = 8'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req, mem_we, IorD, IRWrite, PCWrite, PCWriteCond, BranchNE;
  logic [1:0] PCSrc;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp;
  logic       ExtZero, illegal_op, mem_timeout;
  logic [3:0] state_dbg;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
    .PCSrc(PCSrc), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtZero(ExtZero),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       IorD;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       BranchNE;
    logic [1:0] PCSrc;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       ExtZero;
    logic       illegal_op;
    logic       mem_timeout;
  } outs_t;

  typedef struct {
    outs_t       e;
    outs_t       m;
    bit          chk_fetch;
    logic [63:0] tag;
  } exp_t;

  exp_t  q[$];
  exp_t  mx;
  int    compared = 0;
  int    mismatched = 0;
  outs_t act;

  assign act = {mem_req, mem_we, IorD, IRWrite, PCWrite, PCWriteCond, BranchNE,
                PCSrc, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                ExtZero, illegal_op, mem_timeout};

  // Reference timeout model: length of the current stall and sticky flag.
  int wcnt = 0;
  bit sticky = 1'b0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mx = q.pop_front();
      compared++;
      if ((((act ^ mx.e) & mx.m) !== '0) || (mx.chk_fetch && (state_dbg !== S_FETCH))) begin
        mismatched++;
        $display("FAIL %0s @%0t: outs=%05h state_dbg=%0d, required outs=%05h on care bits %05h%0s",
                 mx.tag, $time, act, state_dbg, mx.e, mx.m, mx.chk_fetch ? " with state_dbg=FETCH" : "");
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

  // Write strobes and status are always checked; mux selects only where
  // the instruction's phase defines them.
  function automatic outs_t smask();
    outs_t o;
    o = '0;
    o.mem_req = 1'b1; o.mem_we = 1'b1; o.IRWrite = 1'b1; o.PCWrite = 1'b1;
    o.PCWriteCond = 1'b1; o.RegWrite = 1'b1; o.illegal_op = 1'b1; o.mem_timeout = 1'b1;
    return o;
  endfunction

  function automatic outs_t alu_mask(input outs_t m, input bit ext);
    outs_t o;
    o = m;
    o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b11; o.ALUOp = 2'b11; o.ExtZero = ext;
    return o;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h02};
  endfunction

  task automatic cyc(input logic [5:0] op, input logic rdy, input bit wait_st,
                     input outs_t e, input outs_t m, input bit chk_fetch, input logic [63:0] tag);
    exp_t x;
    opcode    = op;
    mem_ready = rdy;
    x.e = e; x.m = m; x.chk_fetch = chk_fetch; x.tag = tag;
    if (!rst) x.e.mem_timeout = sticky;
    q.push_back(x);
    @(posedge clk); #1;
    if (rst) begin
      wcnt = 0; sticky = 1'b0;
    end else if (wait_st && !rdy) begin
      if (wcnt < 255) wcnt++;
      if (wcnt >= int'(TMO)) sticky = 1'b1;
    end else begin
      wcnt = 0;
    end
  endtask

  // n reset cycles; every output low, state_dbg FETCH once an edge with rst
  // high has gone by (or already FETCH when reset lands between instructions).
  task automatic do_reset(input int n, input bit in_fetch);
    rst = 1'b1;
    for (int i = 0; i < n; i++)
      cyc(6'($urandom), 1'($urandom), 1'b0, '0, '1, (i > 0) || in_fetch, "RESET");
    rst = 1'b0;
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit abort);
    outs_t e, m;
    logic  r;
    for (int i = 0; i <= fw; i++) begin
      r = (i == fw);
      e = '0; m = alu_mask(smask(), 1'b0); m.IorD = 1'b1; m.PCSrc = 2'b11;
      e.mem_req = 1'b1; e.ALUSrcB = 2'b01; e.IRWrite = r; e.PCWrite = r;
      cyc(6'($urandom), r, 1'b1, e, m, 1'b1, "FETCH");
    end
    e = '0; m = alu_mask(smask(), 1'b1);
    e.ALUSrcB = 2'b11; e.illegal_op = !legal(op);
    cyc(op, 1'($urandom), 1'b0, e, m, 1'b0, "DECODE");
    if (!legal(op)) return;
    case (op)
      6'h23, 6'h2b: begin
        e = '0; m = alu_mask(smask(), 1'b1);
        e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b10;
        cyc(op, 1'($urandom), 1'b0, e, m, 1'b0, "MEMADR");
        for (int i = 0; i <= mw; i++) begin
          if (abort && i == 1) begin
            do_reset(2, 1'b0);
            return;
          end
          r = (i == mw);
          e = '0; m = smask(); m.IorD = 1'b1;
          e.mem_req = 1'b1; e.IorD = 1'b1; e.mem_we = (op == 6'h2b);
          cyc(op, r, 1'b1, e, m, 1'b0, (op == 6'h23) ? "MEMRD" : "MEMWR");
        end
        if (op == 6'h23) begin
          e = '0; m = smask(); m.RegDst = 1'b1; m.MemtoReg = 1'b1;
          e.RegWrite = 1'b1; e.MemtoReg = 1'b1;
          cyc(op, 1'($urandom), 1'b0, e, m, 1'b0, "MEMWB");
        end
      end
      6'h00: begin
        e = '0; m = alu_mask(smask(), 1'b0);
        e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b00; e.ALUOp = 2'b10;
        cyc(op, 1'($urandom), 1'b0, e, m, 1'b0, "EXEC_R");
        e = '0; m = smask(); m.RegDst = 1'b1; m.MemtoReg = 1'b1;
        e.RegWrite = 1'b1; e.RegDst = 1'b1;
        cyc(op, 1'($urandom), 1'b0, e, m, 1'b0, "ALUWB_R");
      end
      6'h08, 6'h0c, 6'h0d: begin
        e = '0; m = alu_mask(smask(), 1'b1);
        e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b10;
        e.ALUOp = (op == 6'h08) ? 2'b00 : 2'b11;
        e.ExtZero = (op != 6'h08);
        cyc(op, 1'($urandom), 1'b0, e, m, 1'b0, "EXEC_I");
        e = '0; m = smask(); m.RegDst = 1'b1; m.MemtoReg = 1'b1;
        e.RegWrite = 1'b1;
        cyc(op, 1'($urandom), 1'b0, e, m, 1'b0, "ALUWB_I");
      end
      6'h04, 6'h05: begin
        e = '0; m = alu_mask(smask(), 1'b0); m.PCSrc = 2'b11; m.BranchNE = 1'b1;
        e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b00; e.ALUOp = 2'b01;
        e.PCWriteCond = 1'b1; e.PCSrc = 2'b01; e.BranchNE = (op == 6'h05);
        cyc(op, 1'($urandom), 1'b0, e, m, 1'b0, "BRANCH");
      end
      default: begin
        e = '0; m = smask(); m.PCSrc = 2'b11;
        e.PCWrite = 1'b1; e.PCSrc = 2'b10;
        cyc(op, 1'($urandom), 1'b0, e, m, 1'b0, "JUMP");
      end
    endcase
  endtask

  initial begin
    logic [5:0] op;
    int         fw, mw, pick;
    rst = 1'b1; opcode = 6'h00; mem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset(2, 1'b1);

    // Directed instructions
    run_instr(6'h0d, 0, 0, 1'b0);   // ORI
    run_instr(6'h08, 0, 0, 1'b0);   // ADDI
    run_instr(6'h0c, 1, 0, 1'b0);   // ANDI, one fetch wait
    run_instr(6'h23, 0, 3, 1'b0);   // LW, 3 waits in MEMRD
    run_instr(6'h2b, 0, 2, 1'b0);   // SW
    run_instr(6'h05, 0, 0, 1'b0);   // BNE
    run_instr(6'h04, 0, 0, 1'b0);   // BEQ
    run_instr(6'h02, 0, 0, 1'b0);   // J
    run_instr(6'h00, 0, 0, 1'b0);   // R-type
    run_instr(6'h3f, 0, 0, 1'b0);   // illegal
    run_instr(6'h23, 0, 3, 1'b1);   // LW aborted by reset in MEMRD
    run_instr(6'h0d, 0, 0, 1'b0);
    run_instr(6'h02, 3, 0, 1'b0);   // 3 fetch waits: no timeout
    run_instr(6'h02, 6, 0, 1'b0);   // 6 fetch waits: timeout sets
    run_instr(6'h2b, 0, 1, 1'b0);   // stays sticky
    do_reset(2, 1'b1);
    run_instr(6'h23, 0, 0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 220; n++) begin
      pick = $urandom_range(0, 11);
      case (pick)
        0: op = 6'h00;  1: op = 6'h23;  2: op = 6'h2b;
        3: op = 6'h04;  4: op = 6'h05;  5: op = 6'h08;
        6: op = 6'h0c;  7: op = 6'h0d;  8: op = 6'h02;
        default: op = 6'($urandom);
      endcase
      fw = ($urandom_range(0, 15) == 0) ? 5 : $urandom_range(0, 2);
      mw = ($urandom_range(0, 15) == 0) ? 6 : $urandom_range(0, 3);
      run_instr(op, fw, mw, ($urandom_range(0, 30) == 0));
      if ($urandom_range(0, 24) == 0) do_reset($urandom_range(1, 2), 1'b1);
    end

    @(negedge clk); #1;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected records left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
